// File: rtl/spi_flash_reader.sv
// Read-only picorv32 memory slave that fetches words from SPI flash with READ (0x03), mode 0.
// CS stays low in HOLD, so consecutive sequential words cost only the 32 data bits.
module spi_flash_reader #(
  parameter int unsigned SCK_DIV      = 2,
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter int unsigned CS_HIGH_MIN  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [23:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy
);

  localparam int unsigned HALF_W = $clog2(SCK_DIV + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned CSHI_W = $clog2(CS_HIGH_MIN + 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [CSHI_W-1:0] CSHI_LAST = CSHI_W'(CS_HIGH_MIN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE, S_HOLD, S_CSHI
  } state_t;

  state_t state_q, state_d;

  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CSHI_W-1:0] cshi_cnt_q, cshi_cnt_d;
  logic              pending_q, pending_d;
  logic [21:0]       addr_q, addr_d;
  logic [21:0]       next_addr_q, next_addr_d;
  logic              next_valid_q, next_valid_d;
  logic [31:0]       tx_q, tx_d, rx_q, rx_d;
  logic              cs_n_d, sck_d, mosi_d, ready_d, busy_d;
  logic [31:0]       rdata_d;
  logic [22:0]       addr_inc;
  logic              unused_addr_bits;

  logic in_shift, tick, rise, fall, last_bit, rd_req, wr_req, seq_hit;

  // Ready gating stops the still-valid request of the completion cycle from being re-accepted.
  assign rd_req   = mem_valid && (mem_wstrb == 4'h0) && !mem_ready;
  assign wr_req   = mem_valid && (mem_wstrb != 4'h0) && !mem_ready;
  assign seq_hit  = next_valid_q && (mem_addr[23:2] == next_addr_q);
  assign in_shift = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign tick     = (half_cnt_q == HALF_LAST);
  assign rise     = in_shift && tick && !spi_sck;
  assign fall     = in_shift && tick && spi_sck;
  assign last_bit = ((state_q == S_CMD)  && (bit_cnt_q == 5'd7))  ||
                    ((state_q == S_ADDR) && (bit_cnt_q == 5'd23)) ||
                    ((state_q == S_DATA) && (bit_cnt_q == 5'd31));
  assign addr_inc = {1'b0, addr_q} + 23'd1;
  assign unused_addr_bits = ^mem_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rd_req) state_d = S_CMD;
      S_CMD:  if (fall && last_bit) state_d = S_ADDR;
      S_ADDR: if (fall && last_bit) state_d = S_DATA;
      S_DATA: if (fall && last_bit) state_d = S_DONE;
      S_DONE: state_d = S_HOLD;
      S_HOLD: begin
        if (rd_req)                        state_d = seq_hit ? S_DATA : S_CSHI;
        else if (idle_cnt_q == IDLE_LAST)  state_d = S_CSHI;
      end
      S_CSHI: if (cshi_cnt_q == CSHI_LAST) state_d = (pending_q || rd_req) ? S_CMD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    half_cnt_d   = '0;
    bit_cnt_d    = '0;
    sck_d        = 1'b0;
    addr_d       = addr_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    ready_d      = 1'b0;
    rdata_d      = mem_rdata;
    next_addr_d  = next_addr_q;
    next_valid_d = next_valid_q;

    if (in_shift) begin
      half_cnt_d = tick ? '0 : half_cnt_q + 1'b1;
      bit_cnt_d  = bit_cnt_q;
      sck_d      = spi_sck;
      if (rise) sck_d = 1'b1;
      if (fall) begin
        sck_d     = 1'b0;
        bit_cnt_d = last_bit ? 5'd0 : bit_cnt_q + 5'd1;
      end
    end

    // A read pending in CSHI keeps the address it was accepted with.
    if (rd_req && ((state_q == S_IDLE) || (state_q == S_HOLD) || ((state_q == S_CSHI) && !pending_q)))
      addr_d = mem_addr[23:2];

    if (fall && (state_q != S_DATA)) tx_d = {tx_q[30:0], 1'b0};
    if ((state_d == S_CMD) && (state_q != S_CMD)) tx_d = {8'h03, addr_d, 2'b00};
    if (rise && (state_q == S_DATA)) rx_d = {rx_q[30:0], spi_miso};

    idle_cnt_d = ((state_q == S_HOLD) && !rd_req) ? idle_cnt_q + 1'b1 : '0;
    cshi_cnt_d = (state_q == S_CSHI) ? cshi_cnt_q + 1'b1 : '0;
    pending_d  = (state_d == S_CSHI) && (pending_q || rd_req);

    if (((state_q == S_IDLE) || (state_q == S_HOLD)) && wr_req) ready_d = 1'b1;

    // Flash streams MSB first per byte; the first byte received lands in rdata[7:0].
    if (state_q == S_DONE) begin
      ready_d      = mem_valid;
      rdata_d      = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
      next_addr_d  = addr_inc[21:0];
      next_valid_d = !addr_inc[22];
    end

    mosi_d = ((state_d == S_CMD) || (state_d == S_ADDR)) ? tx_d[31] : 1'b0;
    cs_n_d = (state_d == S_IDLE) || (state_d == S_CSHI);
    busy_d = !((state_d == S_IDLE) || (state_d == S_HOLD));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      cshi_cnt_q   <= '0;
      pending_q    <= 1'b0;
      addr_q       <= '0;
      next_addr_q  <= '0;
      next_valid_q <= 1'b0;
      tx_q         <= '0;
      rx_q         <= '0;
      spi_cs_n     <= 1'b1;
      spi_sck      <= 1'b0;
      spi_mosi     <= 1'b0;
      mem_ready    <= 1'b0;
      mem_rdata    <= '0;
      busy         <= 1'b0;
    end else begin
      half_cnt_q   <= half_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      cshi_cnt_q   <= cshi_cnt_d;
      pending_q    <= pending_d;
      addr_q       <= addr_d;
      next_addr_q  <= next_addr_d;
      next_valid_q <= next_valid_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      spi_cs_n     <= cs_n_d;
      spi_sck      <= sck_d;
      spi_mosi     <= mosi_d;
      mem_ready    <= ready_d;
      mem_rdata    <= rdata_d;
      busy         <= busy_d;
    end
  end

endmodule
